// File: rtl/pipe_rca_adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder.
// Optional feature macro: ADDER_SUB_EN (adds the subtract request).
package adder_pkg;

   // Per-stage control state: occupancy and the carry out of the stage's chunk
   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctl_t;

   // A legal configuration splits WIDTH into 1..WIDTH equal chunks
   function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
      return (stages >= 32'd1) && (stages <= width) && ((width % stages) == 32'd0);
   endfunction

   // Bits resolved per pipeline stage
   function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
      return (stages == 32'd0) ? width : (width / stages);
   endfunction

endpackage

// File: rtl/pipe_rca_adder_if.sv
// Operand/result handshake bundle for pipe_rca_adder.
// Optional feature macro: ADDER_SUB_EN (adds the sub signal).
interface pipe_rca_adder_if
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef ADDER_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

`ifdef ADDER_SUB_EN
   modport master (output in_valid, a, b, cin, sub, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
   modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
`else
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/pipe_rca_adder_rca_chunk.sv
// Combinational CW-bit ripple-carry chunk built from per-bit full adders.
// Also exposes the carry into its MSB so the last chunk can derive overflow.
module rca_chunk
   import adder_pkg::*;
#(
   parameter int unsigned CW = 16
) (
   input  logic [CW-1:0] i_a,
   input  logic [CW-1:0] i_b,
   input  logic          i_cin,
   output logic [CW-1:0] o_sum,
   output logic          o_cout,
   output logic          o_cmsb
);
   logic [CW:0] w_c;

   // Ripple the carry through one full adder per bit
   always_comb begin
      w_c      = '0;
      o_sum    = '0;
      w_c[0]   = i_cin;
      for (int i = 0; i < int'(CW); i++) begin
         o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
         w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
   end

   assign o_cout = w_c[CW];
   assign o_cmsb = w_c[CW-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder: WIDTH bits resolved CW = WIDTH/STAGES bits per
// stage, carry registered between stages, operands skewed through the pipe.
// Optional feature macro: ADDER_SUB_EN (a - b when bus.sub is set).
module pipe_rca_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4
) (
   input logic             clk,
   input logic             rst_n,
   pipe_rca_adder_if.slave bus
);
   localparam int unsigned CW = chunk_width(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipe_rca_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
   end

   logic [WIDTH-1:0]  w_b_eff;
   logic              w_cin_eff;
   logic [STAGES-1:0] w_valid;
   logic [STAGES-1:0] w_adv;
   logic              w_in_ready;
   logic              w_accept;

`ifdef ADDER_SUB_EN
   // Subtraction feeds ~b with a forced carry-in; cin is ignored in that mode
   always_comb begin
      if (bus.sub) begin
         w_b_eff   = ~bus.b;
         w_cin_eff = 1'b1;
      end else begin
         w_b_eff   = bus.b;
         w_cin_eff = bus.cin;
      end
   end
`else
   // Add-only build: operands pass straight into stage 0
   always_comb begin
      w_b_eff   = bus.b;
      w_cin_eff = bus.cin;
   end
`endif

   // Advance chain from the output back to stage 0 so bubbles collapse
   always_comb begin
      w_adv = '0;
      w_adv[STAGES-1] = bus.out_ready | ~w_valid[STAGES-1];
      for (int k = int'(STAGES) - 2; k >= 0; k--) begin
         w_adv[k] = ~w_valid[k+1] | w_adv[k+1];
      end
   end

   assign w_in_ready   = ~w_valid[0] | w_adv[0];
   assign w_accept     = bus.in_valid & w_in_ready;
   assign bus.in_ready = w_in_ready;

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
      // Operand bits still unconsumed on entry to this stage (chunk k upward)
      localparam int unsigned REM = WIDTH - k * CW;

      stage_ctl_t              r_ctl;
      logic [(k+1)*CW-1:0]     r_sum;
      logic [REM-1:0]          w_a_src;
      logic [REM-1:0]          w_b_src;
      logic                    w_ci;
      logic                    w_load;
      logic [CW-1:0]           w_cs;
      logic                    w_co;
      logic                    w_cm;
      logic [(k+1)*CW-1:0]     w_sum_nxt;

      if (k == 0) begin : g_first
         assign w_a_src   = bus.a;
         assign w_b_src   = w_b_eff;
         assign w_ci      = w_cin_eff;
         assign w_load    = w_accept;
         assign w_sum_nxt = w_cs;
      end else begin : g_next
         assign w_a_src   = g_stage[k-1].g_ops.r_a_rem;
         assign w_b_src   = g_stage[k-1].g_ops.r_b_rem;
         assign w_ci      = g_stage[k-1].r_ctl.carry;
         assign w_load    = g_stage[k-1].r_ctl.valid;
         assign w_sum_nxt = {w_cs, g_stage[k-1].r_sum};
      end

      rca_chunk #(.CW(CW)) u_chunk (
         .i_a    (w_a_src[CW-1:0]),
         .i_b    (w_b_src[CW-1:0]),
         .i_cin  (w_ci),
         .o_sum  (w_cs),
         .o_cout (w_co),
         .o_cmsb (w_cm)
      );

      assign w_valid[k] = r_ctl.valid;

      // Stage control and accumulated sum: load on advance, hold while stalled
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_ctl <= '0;
            r_sum <= '0;
         end else if (w_adv[k]) begin
            r_ctl.valid <= w_load;
            r_ctl.carry <= w_co;
            r_sum       <= w_sum_nxt;
         end
      end

      if (k < int'(STAGES) - 1) begin : g_ops
         logic [REM-CW-1:0] r_a_rem;
         logic [REM-CW-1:0] r_b_rem;

         // Skew the unconsumed operand chunks forward with their partial sum
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a_rem <= '0;
               r_b_rem <= '0;
            end else if (w_adv[k]) begin
               r_a_rem <= w_a_src[REM-1:CW];
               r_b_rem <= w_b_src[REM-1:CW];
            end
         end
      end

      if (k == int'(STAGES) - 1) begin : g_last
         logic r_cmsb;

         // Record the carry into bit WIDTH-1 for the overflow flag
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cmsb <= 1'b0;
            end else if (w_adv[k]) begin
               r_cmsb <= w_cm;
            end
         end

         assign bus.out_valid = r_ctl.valid;
         assign bus.sum       = r_sum;
         assign bus.cout      = r_ctl.carry;
         assign bus.ovf       = r_cmsb ^ r_ctl.carry;
      end else begin : g_mid
         logic w_unused_cmsb;
         assign w_unused_cmsb = w_cm;
      end
   end

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Directed self-checking bench for pipe_rca_adder (STAGES=4 and STAGES=1).
// Subtract vectors are exercised when ADDER_SUB_EN is defined.
module tb_pipe_rca_adder;
   localparam int unsigned W = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   pipe_rca_adder_if #(.WIDTH(W)) bus4 ();
   pipe_rca_adder_if #(.WIDTH(W)) bus1 ();

   pipe_rca_adder #(.WIDTH(W), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   pipe_rca_adder #(.WIDTH(W), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction through the 4-stage pipe, checking latency and result
   task automatic run4(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic [63:0] es, input logic ec, input logic eo);
      int n;
      bus4.a = a;
      bus4.b = b;
      bus4.cin = c;
      bus4.in_valid = 1'b1;
      #1;
      check({tag, "_in_ready"}, bus4.in_ready, 64'd1);
      tick();
      bus4.in_valid = 1'b0;
      n = 1;
      while (bus4.out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'd4);
      check({tag, "_sum"}, bus4.sum, es);
      check({tag, "_cout"}, bus4.cout, ec);
      check({tag, "_ovf"}, bus4.ovf, eo);
      tick();
      check({tag, "_drained"}, bus4.out_valid, 64'd0);
   endtask

   initial begin
      logic [63:0] exp_q[$];
      logic [63:0] va;
      logic [63:0] vb;
      logic [63:0] prev_sum;
      logic [63:0] want;
      logic        prev_stall;
      logic        acc_in;
      logic        acc_out;
      logic        saw_full;
      int          sent;
      int          recv;
      int          held;
      int          seen;

      bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b1;
`ifdef ADDER_SUB_EN
      bus4.sub = 1'b0;
      bus1.sub = 1'b0;
`endif

      // Reset state
      #12;
      check("rst_out_valid", bus4.out_valid, 64'd0);
      check("rst_sum", bus4.sum, 64'd0);
      check("rst_cout", bus4.cout, 64'd0);
      check("rst_ovf", bus4.ovf, 64'd0);
      check("rst_in_ready", bus4.in_ready, 64'd1);
      check("rst_s1_out_valid", bus1.out_valid, 64'd0);
      tick();
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", bus4.in_ready, 64'd1);

      // Directed arithmetic vectors
      run4("single", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
      run4("chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b0);
      run4("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
      run4("novf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1);
`ifdef ADDER_SUB_EN
      bus4.sub = 1'b1;
      run4("sub", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      bus4.sub = 1'b0;
`endif

      // Back-pressure: 8 back-to-back adds, out_ready low in cycles 3..9
      sent = 0; recv = 0; prev_stall = 1'b0; prev_sum = '0; saw_full = 1'b0;
      bus4.cin = 1'b0;
      for (int c = 0; c < 40; c++) begin
         bus4.out_ready = (c >= 3 && c <= 9) ? 1'b0 : 1'b1;
         if (sent < 8) begin
            va = 64'h0123_4567_89AB_CDEF * 64'(sent + 1);
            vb = {32'(sent), 32'hFFFF_FFFF};
            bus4.a = va;
            bus4.b = vb;
            bus4.in_valid = 1'b1;
         end else begin
            bus4.in_valid = 1'b0;
         end
         #1;
         held = sent - recv;
         if (held == 4 && !bus4.out_ready) saw_full = 1'b1;
         check("bp_in_ready", bus4.in_ready, (held < 4 || bus4.out_ready) ? 64'd1 : 64'd0);
         if (prev_stall) check("bp_stable", bus4.sum, prev_sum);
         acc_in  = bus4.in_valid & bus4.in_ready;
         acc_out = bus4.out_valid & bus4.out_ready;
         if (acc_out) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            check("bp_order", bus4.sum, want);
            recv++;
         end
         prev_stall = bus4.out_valid & ~bus4.out_ready;
         prev_sum   = bus4.sum;
         if (acc_in) begin
            exp_q.push_back(va + vb);
            sent++;
         end
         tick();
      end
      check("bp_saw_full", 64'(saw_full), 64'd1);
      check("bp_sent", 64'(sent), 64'd8);
      check("bp_recv", 64'(recv), 64'd8);
      bus4.out_ready = 1'b1;

      // Reset with three results in flight
      for (int i = 0; i < 3; i++) begin
         bus4.a = 64'(i + 1);
         bus4.b = 64'(i + 1);
         bus4.in_valid = 1'b1;
         tick();
      end
      bus4.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", bus4.out_valid, 64'd0);
      check("mid_rst_sum", bus4.sum, 64'd0);
      check("mid_rst_in_ready", bus4.in_ready, 64'd1);
      tick();
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus4.out_valid === 1'b1) seen++;
      end
      check("mid_rst_no_output", 64'(seen), 64'd0);

      // Single-stage instance: result valid the cycle after accept
      bus1.a = 64'h7FFF_FFFF_FFFF_FFFF;
      bus1.b = 64'd1;
      bus1.in_valid = 1'b1;
      #1;
      check("s1_pre_valid", bus1.out_valid, 64'd0);
      check("s1_in_ready", bus1.in_ready, 64'd1);
      tick();
      bus1.in_valid = 1'b0;
      check("s1_valid", bus1.out_valid, 64'd1);
      check("s1_sum", bus1.sum, 64'h8000_0000_0000_0000);
      check("s1_cout", bus1.cout, 64'd0);
      check("s1_ovf", bus1.ovf, 64'd1);
      tick();
      check("s1_drained", bus1.out_valid, 64'd0);
`ifdef ADDER_SUB_EN
      bus1.a = 64'd5;
      bus1.b = 64'd7;
      bus1.cin = 1'b1;
      bus1.sub = 1'b1;
      bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      check("s1_sub_valid", bus1.out_valid, 64'd1);
      check("s1_sub_sum", bus1.sum, 64'hFFFF_FFFF_FFFF_FFFE);
      check("s1_sub_cout", bus1.cout, 64'd0);
      check("s1_sub_ovf", bus1.ovf, 64'd0);
      bus1.sub = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pipe_rca_adder.md
# pipe_rca_adder

Parametrised, pipelined ripple-carry adder, the successor to the team's single-bit full-adder cell. It splits a WIDTH-bit addition into STAGES equal chunks and resolves one chunk per pipeline stage, passing the carry forward between registers. Operands enter through a valid/ready handshake and results leave through one. It sits between the operand-fetch logic and the result writeback in the arithmetic datapath, sustaining one addition per clock.

## Interface
Parameters:
- WIDTH, 64, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages, 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operands a, b and cin are presented.
- in_ready  out  1  stage 0 can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- sub  in  1  subtract request; present only with ADDER_SUB_EN.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow: carry into bit WIDTH-1 XOR cout.

## Operation
- Each stage k (0..STAGES-1) holds a valid bit, the remaining operand chunks, the accumulated sum chunks 0..k and the carry out of chunk k.
- Stage 0 computes chunk 0 of a+b+cin and captures it together with the upper operand chunks.
- Stage k>0 computes chunk k using the operands and carry held in stage k-1.
- Operands are skewed through the pipe. Already-computed sum chunks are carried forward unchanged.
- Advance rule:
  - The last stage advances when out_ready is high or its valid bit is clear.
  - Stage k<STAGES-1 advances when stage k+1 is empty or stage k+1 advances.
  - Bubbles collapse.
- in_ready = stage 0 empty OR stage 0 advances. This is combinational from out_ready through the chain; there is no registered skid.
- A transfer occurs on an edge where in_valid && in_ready. A stage whose predecessor does not deliver a transfer clears its valid bit when it advances.
- Stalled stages hold all contents. sum, cout and ovf stay stable while out_valid && !out_ready.
- Outputs are driven directly from the last stage's registers.
- ovf needs the carry into the MSB. The last stage records it: it is bit CW-1's carry-in of chunk STAGES-1.

## Timing
- Reset (asynchronous assert, synchronous to clk on release):
  - All valid bits clear.
  - sum = 0, cout = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 while reset is asserted and on the first cycle after it.
- Latency is STAGES edges, counting the accept edge. An operand accepted at edge E appears with out_valid = 1 after edge E+STAGES-1.
- With STAGES = 1, the result is valid the cycle after acceptance.
- Throughput is one result per cycle while out_ready stays high.
- When the pipe is full and out_ready = 0, in_ready = 0. No input is lost or duplicated.
- When the pipe is full and out_ready rises, the output handoff and a new input accept happen on the same edge.
- Reset mid-operation discards all in-flight results without producing output.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH. cout is bit WIDTH of the unbounded result.

## Configuration
- ADDER_SUB_EN defined:
  - The sub port exists and is sampled with the operands.
  - When sub = 1, stage 0 uses ~b and a forced carry-in of 1, so the result is a − b and cin is ignored.
  - cout = 1 means no borrow. ovf is signed subtraction overflow.
  - sub travels with its operand; inverted chunks of b are stored in the pipe.
- Not defined: the sub port is absent and the block adds only.

## Structure
- Package adder_pkg: a compile-time check function that WIDTH % STAGES == 0, and a helper that computes chunk width.
- Sub-module rca_chunk: a combinational CW-bit ripple chunk built from per-bit full-adder equations.
  - Outputs: sum chunk, carry out, and carry into its MSB (used for ovf).
  - The top instantiates one rca_chunk per stage in a generate loop.

## Test plan
Unless stated, WIDTH = 64, STAGES = 4, out_ready = 1.
- Single add: a = 0x0000_0000_FFFF_FFFF, b = 1, cin = 0 → after 4 edges, sum = 0x0000_0001_0000_0000, cout = 0, ovf = 0. The carry crosses chunks 1→2.
- Full carry chain: a = all ones, b = 0, cin = 1 → sum = 0, cout = 1, ovf = 0.
- Signed overflow: a = 0x7FFF_FFFF_FFFF_FFFF, b = 1 → sum = 0x8000_0000_0000_0000, ovf = 1, cout = 0.
- Back-pressure: stream 8 back-to-back adds with out_ready = 0 from cycle 3 to 9 → in_ready falls once 4 results are held. Results emerge in order with no loss or duplication, and sum stays stable during the stall.
- Reset mid-stream: assert rst_n = 0 with 3 results in flight → out_valid = 0 and sum = 0 immediately; nothing emerges after release.
- With ADDER_SUB_EN and sub = 1: a = 5, b = 7 → sum = 0xFFFF_FFFF_FFFF_FFFE, cout = 0, ovf = 0. Repeat with STAGES = 1 → result valid one cycle after accept.
